rom_load_sequencer: RTL and testbench

- Sequences the HPS ROM download stream (ioctl byte writes) into the arcade core's ROM regions: CPU ROM, tile gfx, sprite gfx and colour PROM.
- Buffers writes through a 2-entry FIFO to a shared ROM write port that can stall, and decodes each address into a one-hot region write enable plus a region-relative offset.
- Owns the core reset: holds the core in reset during download and for a fixed settle period afterwards, and refuses to release it after a malformed download.

---
 rtl/rom_load_sequencer_if.sv | 35 +++
 rtl/rom_load_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_load_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rom_load_sequencer_if
//  Description : Download stream (HPS ioctl side) and shared ROM write port
//                bundled for the ROM load sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface rom_load_sequencer_if #(
    parameter int ADDR_W = 17
);
    // HPS download stream
    logic                dl_active;
    logic                dl_wr;
    logic [ADDR_W-1:0]   dl_addr;
    logic [7:0]          dl_data;
    logic                dl_wait;
    // Shared ROM write port
    logic                mem_ready;
    logic [3:0]          mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [7:0]          mem_data;

    // Side that produces the download and owns the ROM port readiness
    modport master (
        output dl_active, dl_wr, dl_addr, dl_data, mem_ready,
        input  dl_wait, mem_we, mem_addr, mem_data
    );

    // The sequencer itself
    modport slave (
        input  dl_active, dl_wr, dl_addr, dl_data, mem_ready,
        output dl_wait, mem_we, mem_addr, mem_data
    );
endinterface
`default_nettype wire

// File: rtl/rom_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rom_load_sequencer
//  Description : Routes the HPS ROM download through a 2-entry FIFO into the
//                shared ROM write port (one-hot region enable + offset) and
//                owns the core reset around the download.
//  Revision    : 1.0  initial release
// ============================================================================
module rom_load_sequencer #(
    parameter int ADDR_W    = 17,
    parameter int R1_BASE   = 'h06000,
    parameter int R2_BASE   = 'h07000,
    parameter int R3_BASE   = 'h08000,
    parameter int TOTAL_LEN = 'h08040,
    parameter int HOLD_CYC  = 64
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    rom_load_sequencer_if.slave  dl_bus,
    output logic                 core_reset,
    output logic                 dl_done,
    output logic [2:0]           dl_error,
    output logic [ADDR_W:0]      byte_count
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_RUN   = 3'd4;

    localparam logic [ADDR_W-1:0] c_R1_BASE   = ADDR_W'(R1_BASE);
    localparam logic [ADDR_W-1:0] c_R2_BASE   = ADDR_W'(R2_BASE);
    localparam logic [ADDR_W-1:0] c_R3_BASE   = ADDR_W'(R3_BASE);
    localparam logic [ADDR_W:0]   c_TOTAL_LEN = (ADDR_W+1)'(TOTAL_LEN);
    localparam int                c_HOLD_W    = $clog2(HOLD_CYC + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYC - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(HOLD_CYC);

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic                r_act_d;
    logic [1:0]          r_cnt;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_fifo_rgn [0:1];
    logic [ADDR_W-1:0]   r_fifo_off [0:1];
    logic [7:0]          r_fifo_dat [0:1];
    logic [ADDR_W-1:0]   r_max_addr;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [3:0]          r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [7:0]          r_mem_data;
    logic                r_dl_wait;
    logic                r_core_reset;
    logic                r_dl_done;
    logic [2:0]          r_dl_error;
    logic [ADDR_W:0]     r_byte_count;

    logic                w_rise;
    logic                w_load_start;
    logic                w_wr;
    logic                w_oor;
    logic                w_ovr;
    logic                w_push;
    logic                w_pop;
    logic                w_store;
    logic                w_take;
    logic [1:0]          w_cnt_next;
    logic [1:0]          w_rgn;
    logic [ADDR_W-1:0]   w_off;
    logic [1:0]          w_head_rgn;
    logic [ADDR_W-1:0]   w_head_off;
    logic [7:0]          w_head_dat;
    logic                w_drain_empty;
    logic                w_len_ok;
    logic                w_short_fail;
    logic                w_hold_done;
    logic                w_enter_run;
    logic [ADDR_W-1:0]   w_max_base;

    // A write counts on any cycle dl_active is high and on the cycle it falls
    assign w_rise       = dl_bus.dl_active & ~r_act_d;
    assign w_load_start = w_rise & ((r_state == c_IDLE) | (r_state == c_RUN) | (r_state == c_HOLD));
    assign w_wr         = dl_bus.dl_wr & (dl_bus.dl_active | r_act_d);
    assign w_oor        = w_wr & ({1'b0, dl_bus.dl_addr} >= c_TOTAL_LEN);
    assign w_ovr        = w_wr & ~w_oor & (r_cnt == 2'd2);
    assign w_push       = w_wr & ~w_oor & (r_cnt != 2'd2);

    // An empty FIFO forwards the incoming byte straight to the ROM port
    assign w_pop        = dl_bus.mem_ready & ((r_cnt != 2'd0) | w_push);
    assign w_take       = w_pop & (r_cnt != 2'd0);
    assign w_store      = w_push & ~(w_pop & (r_cnt == 2'd0));
    assign w_cnt_next   = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

    assign w_drain_empty = (r_state == c_DRAIN) & (r_cnt == 2'd0) & ~w_push;
    assign w_len_ok      = (({1'b0, r_max_addr} + (ADDR_W+1)'(1)) == c_TOTAL_LEN);
    assign w_short_fail  = w_drain_empty & ~w_len_ok;
    // Hold time is measured from the last ROM write, so the core sees a
    // fixed quiet period regardless of how late dl_active dropped
    assign w_hold_done   = (r_hold_cnt >= c_HOLD_LAST);
    assign w_enter_run   = (r_state == c_HOLD) & ~w_rise & w_hold_done;
    assign w_max_base    = w_load_start ? '0 : r_max_addr;

    // Region decode of the incoming address into region index and offset
    always_comb begin
        w_rgn = 2'd3;
        w_off = dl_bus.dl_addr - c_R3_BASE;
        if (dl_bus.dl_addr < c_R1_BASE) begin
            w_rgn = 2'd0;
            w_off = dl_bus.dl_addr;
        end else if (dl_bus.dl_addr < c_R2_BASE) begin
            w_rgn = 2'd1;
            w_off = dl_bus.dl_addr - c_R1_BASE;
        end else if (dl_bus.dl_addr < c_R3_BASE) begin
            w_rgn = 2'd2;
            w_off = dl_bus.dl_addr - c_R2_BASE;
        end
    end

    // Oldest entry, or the incoming byte when the FIFO is empty
    always_comb begin
        w_head_rgn = w_rgn;
        w_head_off = w_off;
        w_head_dat = dl_bus.dl_data;
        if (r_cnt != 2'd0) begin
            w_head_rgn = r_fifo_rgn[r_rd_ptr];
            w_head_off = r_fifo_off[r_rd_ptr];
            w_head_dat = r_fifo_dat[r_rd_ptr];
        end
    end

    // Next-state logic for the download sequencing FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE, c_RUN: begin
                if (w_rise) w_state_next = c_LOAD;
            end
            c_HOLD: begin
                if (w_rise)           w_state_next = c_LOAD;
                else if (w_hold_done) w_state_next = c_RUN;
            end
            c_LOAD: begin
                if (!dl_bus.dl_active) w_state_next = c_DRAIN;
            end
            c_DRAIN: begin
                if (w_drain_empty) begin
                    w_state_next = (w_len_ok && (r_dl_error == 3'b000)) ? c_HOLD : c_IDLE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    // FIFO storage; contents are only meaningful below the count
    always_ff @(posedge clk_sys) begin
        if (w_store) begin
            r_fifo_rgn[r_wr_ptr] <= w_rgn;
            r_fifo_off[r_wr_ptr] <= w_off;
            r_fifo_dat[r_wr_ptr] <= dl_bus.dl_data;
        end
    end

    // FSM, FIFO control, ROM port outputs and status registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_act_d      <= 1'b0;
            r_cnt        <= 2'd0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_max_addr   <= '0;
            r_hold_cnt   <= '0;
            r_mem_we     <= 4'd0;
            r_mem_addr   <= '0;
            r_mem_data   <= 8'd0;
            r_dl_wait    <= 1'b0;
            r_core_reset <= 1'b1;
            r_dl_done    <= 1'b0;
            r_dl_error   <= 3'b000;
            r_byte_count <= '0;
        end else begin
            r_state   <= w_state_next;
            r_act_d   <= dl_bus.dl_active;
            r_cnt     <= w_cnt_next;
            r_dl_wait <= (w_cnt_next == 2'd2);
            if (w_store) r_wr_ptr <= ~r_wr_ptr;
            if (w_take)  r_rd_ptr <= ~r_rd_ptr;

            r_mem_we <= w_pop ? (4'b0001 << w_head_rgn) : 4'd0;
            if (w_pop) begin
                r_mem_addr <= w_head_off;
                r_mem_data <= w_head_dat;
            end

            if (w_pop || w_load_start)    r_hold_cnt <= '0;
            else if (r_hold_cnt != c_HOLD_MAX) r_hold_cnt <= r_hold_cnt + 1'b1;

            r_max_addr   <= (w_push && (dl_bus.dl_addr > w_max_base)) ? dl_bus.dl_addr : w_max_base;
            r_byte_count <= (w_load_start ? '0 : r_byte_count) + {{ADDR_W{1'b0}}, w_push};
            r_dl_error   <= (w_load_start ? 3'b000 : r_dl_error) | {w_short_fail, w_oor, w_ovr};

            r_dl_done <= w_enter_run;
            if (w_load_start)     r_core_reset <= 1'b1;
            else if (w_enter_run) r_core_reset <= 1'b0;
        end
    end

    assign dl_bus.dl_wait  = r_dl_wait;
    assign dl_bus.mem_we   = r_mem_we;
    assign dl_bus.mem_addr = r_mem_addr;
    assign dl_bus.mem_data = r_mem_data;
    assign core_reset      = r_core_reset;
    assign dl_done         = r_dl_done;
    assign dl_error        = r_dl_error;
    assign byte_count      = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_rom_load_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_load_sequencer
//  Description : Self-checking bench for rom_load_sequencer with a queue-based
//                reference model of the download path.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_load_sequencer;

    localparam int ADDR_W    = 17;
    localparam int TOTAL_LEN = 'h08040;
    localparam int HOLD_CYC  = 64;

    typedef struct {
        logic [3:0]        we;
        logic [ADDR_W-1:0] off;
        logic [7:0]        dat;
    } ent_t;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              core_reset;
    logic              dl_done;
    logic [2:0]        dl_error;
    logic [ADDR_W:0]   byte_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    ent_t              q[$];
    int                m_count;
    logic [2:0]        m_err;
    logic              m_prev;
    logic [3:0]        e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_data;
    logic              e_wait;
    bit                err_en;

    rom_load_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    rom_load_sequencer #(
        .ADDR_W    (ADDR_W),
        .R1_BASE   ('h06000),
        .R2_BASE   ('h07000),
        .R3_BASE   ('h08000),
        .TOTAL_LEN (TOTAL_LEN),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .dl_bus     (bus),
        .core_reset (core_reset),
        .dl_done    (dl_done),
        .dl_error   (dl_error),
        .byte_count (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t decode(input int a, input logic [7:0] d);
        ent_t e;
        e.dat = d;
        if (a < 'h06000)      begin e.we = 4'b0001; e.off = ADDR_W'(a);           end
        else if (a < 'h07000) begin e.we = 4'b0010; e.off = ADDR_W'(a - 'h06000); end
        else if (a < 'h08000) begin e.we = 4'b0100; e.off = ADDR_W'(a - 'h07000); end
        else                  begin e.we = 4'b1000; e.off = ADDR_W'(a - 'h08000); end
        return e;
    endfunction

    // One clock of the reference: accept/drop, queue the byte, then retire the oldest
    task automatic model_step();
        ent_t e;
        int   a;
        if (!reset_n) begin
            q.delete();
            m_count = 0;
            m_err   = 3'b000;
            m_prev  = 1'b0;
            e_we    = 4'd0;
            e_wait  = 1'b0;
            return;
        end
        a = int'(bus.dl_addr);
        if (bus.dl_active && !m_prev) begin
            m_count = 0;
            m_err   = 3'b000;
        end
        if (bus.dl_wr && (bus.dl_active || m_prev)) begin
            if (a >= TOTAL_LEN)     m_err[1] = 1'b1;
            else if (q.size() == 2) m_err[0] = 1'b1;
            else begin
                q.push_back(decode(a, bus.dl_data));
                m_count++;
            end
        end
        e_we = 4'd0;
        if (bus.mem_ready && q.size() > 0) begin
            e      = q.pop_front();
            e_we   = e.we;
            e_addr = e.off;
            e_data = e.dat;
        end
        e_wait = (q.size() == 2);
        m_prev = bus.dl_active;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        if (e_we != 4'd0) begin
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
            chk("mem_data", 32'(bus.mem_data), 32'(e_data));
        end
        chk("dl_wait", 32'(bus.dl_wait), 32'(e_wait));
        chk("byte_count", 32'(byte_count), 32'(m_count));
        if (err_en) chk("dl_error", 32'(dl_error), 32'(m_err));
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_mem_we"},     32'(bus.mem_we), 0);
        chk({pfx, "_mem_addr"},   32'(bus.mem_addr), 0);
        chk({pfx, "_mem_data"},   32'(bus.mem_data), 0);
        chk({pfx, "_dl_wait"},    32'(bus.dl_wait), 0);
        chk({pfx, "_core_reset"}, 32'(core_reset), 1);
        chk({pfx, "_dl_done"},    32'(dl_done), 0);
        chk({pfx, "_dl_error"},   32'(dl_error), 0);
        chk({pfx, "_byte_count"}, 32'(byte_count), 0);
    endtask

    initial begin
        int          hold_at;
        int          done_at;
        int          done_cnt;
        int          rel_cnt;
        logic [7:0]  d1;
        logic [7:0]  d2;
        int          bnd [8];
        int          sel;
        int          a;

        bnd = '{'h0, 'h5FFF, 'h6000, 'h6FFF, 'h7000, 'h7FFF, 'h8000, 'h803F};
        reset_n       = 1'b0;
        bus.dl_active = 1'b0;
        bus.dl_wr     = 1'b0;
        bus.dl_addr   = '0;
        bus.dl_data   = 8'd0;
        bus.mem_ready = 1'b1;
        err_en        = 1'b1;

        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // ---------------- nominal full load ----------------
        bus.dl_active = 1'b1;
        tick();
        for (int i = 0; i < TOTAL_LEN - 1; i++) begin
            bus.dl_wr   = 1'b1;
            bus.dl_addr = ADDR_W'(i);
            bus.dl_data = 8'(i);
            tick();
            if (i == 0) begin
                chk("nom_first_we", 32'(bus.mem_we), 32'h1);
                chk("nom_first_addr", 32'(bus.mem_addr), 0);
            end
            if (i == 'h06000) begin
                chk("nom_r1_we", 32'(bus.mem_we), 32'h2);
                chk("nom_r1_addr", 32'(bus.mem_addr), 0);
            end
        end
        // last byte arrives on the cycle dl_active falls
        bus.dl_active = 1'b0;
        bus.dl_addr   = ADDR_W'('h0803F);
        bus.dl_data   = 8'h3F;
        tick();
        chk("nom_last_we", 32'(bus.mem_we), 32'h8);
        chk("nom_last_addr", 32'(bus.mem_addr), 32'h3F);
        chk("nom_last_data", 32'(bus.mem_data), 32'h3F);
        bus.dl_wr = 1'b0;
        err_en    = 1'b0;
        hold_at = 0; done_at = 0; done_cnt = 0;
        for (int c = 1; c <= HOLD_CYC + 20; c++) begin
            tick();
            if (dl_done) begin
                done_cnt++;
                done_at = c;
            end
            if (hold_at == 0 && !core_reset) hold_at = c;
        end
        chk("nom_hold_cycles", 32'(hold_at), HOLD_CYC);
        chk("nom_done_pulses", 32'(done_cnt), 1);
        chk("nom_done_at", 32'(done_at), HOLD_CYC);
        chk("nom_core_reset", 32'(core_reset), 0);
        chk("nom_byte_count", 32'(byte_count), 32'h08040);
        chk("nom_dl_error", 32'(dl_error), 0);

        // ---------------- reload from RUN ----------------
        bus.dl_active = 1'b1;
        tick();
        err_en = 1'b1;
        chk("reload_core_reset", 32'(core_reset), 1);
        chk("reload_byte_count", 32'(byte_count), 0);
        chk("reload_dl_error", 32'(dl_error), 0);

        // backpressure: three writes against a stalled port
        bus.mem_ready = 1'b0;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        bus.dl_wr   = 1'b1;
        bus.dl_addr = ADDR_W'($urandom_range(0, 'h0803F));
        bus.dl_data = d1;
        tick();
        chk("bp_wait_after1", 32'(bus.dl_wait), 0);
        bus.dl_addr = ADDR_W'($urandom_range(0, 'h0803F));
        bus.dl_data = d2;
        tick();
        chk("bp_wait_after2", 32'(bus.dl_wait), 1);
        bus.dl_addr = ADDR_W'($urandom_range(0, 'h0803F));
        bus.dl_data = 8'($urandom);
        tick();
        chk("bp_dl_error", 32'(dl_error), 32'h1);
        chk("bp_byte_count", 32'(byte_count), 2);
        bus.dl_wr     = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        chk("bp_pop1_data", 32'(bus.mem_data), 32'(d1));
        tick();
        chk("bp_pop2_data", 32'(bus.mem_data), 32'(d2));
        tick();
        chk("bp_idle_we", 32'(bus.mem_we), 0);

        // out-of-range address
        bus.dl_wr   = 1'b1;
        bus.dl_addr = ADDR_W'('h08040);
        tick();
        bus.dl_wr = 1'b0;
        tick();
        chk("oor_we", 32'(bus.mem_we), 0);
        chk("oor_dl_error", 32'(dl_error), 32'h3);
        chk("oor_byte_count", 32'(byte_count), 2);

        // randomized traffic while in LOAD
        for (int c = 0; c < 3000; c++) begin
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = int'($urandom_range('h08040, 'h1FFFF));
            else if (sel == 1) a = bnd[$urandom_range(0, 7)];
            else               a = int'($urandom_range(0, 'h0803F));
            bus.dl_wr     = 1'($urandom_range(0, 1));
            bus.dl_addr   = ADDR_W'(a);
            bus.dl_data   = 8'($urandom);
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // asynchronous reset with data still queued
        bus.mem_ready = 1'b0;
        bus.dl_wr     = 1'b1;
        bus.dl_addr   = ADDR_W'('h00010);
        tick();
        bus.dl_addr   = ADDR_W'('h07010);
        tick();
        bus.dl_wr     = 1'b0;
        reset_n       = 1'b0;
        #1;
        check_reset_values("midrst");
        bus.dl_active = 1'b0;
        tick();
        reset_n       = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (4) tick();
        chk("midrst_fifo_empty", 32'(bus.mem_we), 0);

        // ---------------- short download ----------------
        bus.dl_active = 1'b1;
        tick();
        for (int i = 0; i < 'h07FFF; i++) begin
            bus.dl_wr   = 1'b1;
            bus.dl_addr = ADDR_W'(i);
            bus.dl_data = 8'(i);
            tick();
        end
        bus.dl_active = 1'b0;
        bus.dl_addr   = ADDR_W'('h07FFF);
        bus.dl_data   = 8'hFF;
        tick();
        chk("short_last_we", 32'(bus.mem_we), 32'h4);
        chk("short_last_addr", 32'(bus.mem_addr), 32'hFFF);
        bus.dl_wr = 1'b0;
        err_en    = 1'b0;
        done_cnt = 0; rel_cnt = 0;
        for (int c = 1; c <= HOLD_CYC + 20; c++) begin
            tick();
            if (dl_done)     done_cnt++;
            if (!core_reset) rel_cnt++;
        end
        chk("short_done_pulses", 32'(done_cnt), 0);
        chk("short_core_released", 32'(rel_cnt), 0);
        chk("short_dl_error", 32'(dl_error), 32'h4);
        chk("short_byte_count", 32'(byte_count), 32'h08000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
